// File: rtl/msrv32_pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// msrv32_pc_redirect_unit
//
// Owns the architectural fetch PC of the msrv32 core. It takes the resolved
// branch decision from the execute stage, forms the redirect target
// (JAL / JALR / BRANCH), loads the PC, and raises a one-cycle flush after
// every redirect. A target with bit 1 set is reported as a misaligned
// instruction fetch. The trap unit may override the PC at any time.
//
// Parameters:
//   BOOT_ADDRESS     PC value loaded on reset.
//   TAKEN_COUNT_MAX  value at which taken_count_out saturates.
//
// Ports:
//   ms_riscv32_mp_clk_in   in   1   core clock, rising edge
//   ms_riscv32_mp_rst_in   in   1   synchronous active-high reset
//   branch_taken_in        in   1   branch/jump resolved taken
//   opcode_6_to_2_in       in   5   execute-stage opcode bits [6:2]
//   pc_ex_in               in  32   execute-stage PC
//   rs1_in                 in  32   rs1 operand (JALR base)
//   imm_in                 in  32   sign-extended immediate
//   stall_in               in   1   hold the PC, drop branches
//   trap_taken_in          in   1   trap / mret redirect request
//   trap_address_in        in  32   trap / mret target
//   pc_out                 out 32   registered fetch PC
//   pc_plus_4_out          out 32   pc_out + 4 (combinational)
//   flush_out              out  1   registered wrong-path kill
//   misaligned_instr_out   out  1   registered misaligned-target pulse
//   taken_count_out        out 32   saturating count of accepted redirects
// -----------------------------------------------------------------------------
module msrv32_pc_redirect_unit #(
  parameter logic [31:0] BOOT_ADDRESS    = 32'h0000_0000,
  parameter logic [31:0] TAKEN_COUNT_MAX = 32'hFFFF_FFFF
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        branch_taken_in,
  input  logic [4:0]  opcode_6_to_2_in,
  input  logic [31:0] pc_ex_in,
  input  logic [31:0] rs1_in,
  input  logic [31:0] imm_in,
  input  logic        stall_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_address_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic        flush_out,
  output logic        misaligned_instr_out,
  output logic [31:0] taken_count_out
);

  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  typedef enum logic [1:0] {
    S_BOOT      = 2'd0,
    S_RUN       = 2'd1,
    S_FLUSH     = 2'd2,
    S_WAIT_TRAP = 2'd3
  } state_t;

  // JALR clears bit 0 of its sum; JAL and BRANCH are PC-relative.
  function automatic logic [31:0] redirect_target(
    input logic [4:0]  opcode,
    input logic [31:0] pc_ex,
    input logic [31:0] rs1,
    input logic [31:0] imm
  );
    logic [31:0] sum;
    if (opcode == OP_JALR) begin
      sum = (rs1 + imm) & 32'hFFFF_FFFE;
    end else begin
      sum = pc_ex + imm;
    end
    return sum;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic        flush_r;
  logic        flush_nxt_s;
  logic        misaligned_r;
  logic        misaligned_nxt_s;
  logic [31:0] count_r;
  logic [31:0] count_nxt_s;
  logic        branch_ok_s;
  logic [31:0] target_s;
  logic [31:0] count_inc_s;

  // Only control-transfer opcodes can redirect; anything else is ignored.
  assign branch_ok_s = branch_taken_in &
                       ((opcode_6_to_2_in == OP_JAL)  ||
                        (opcode_6_to_2_in == OP_JALR) ||
                        (opcode_6_to_2_in == OP_BRANCH));
  assign target_s    = redirect_target(opcode_6_to_2_in, pc_ex_in, rs1_in, imm_in);
  assign count_inc_s = (count_r == TAKEN_COUNT_MAX) ? count_r : (count_r + 32'd1);

  // Next-state and next-output decode; trap beats stall beats branch.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    flush_nxt_s      = 1'b0;
    misaligned_nxt_s = 1'b0;
    count_nxt_s      = count_r;
    case (state_r)
      S_BOOT: begin
        state_nxt_s = S_RUN;
      end
      S_RUN: begin
        if (trap_taken_in) begin
          pc_nxt_s    = trap_address_in;
          flush_nxt_s = 1'b1;
          state_nxt_s = S_FLUSH;
        end else if (stall_in) begin
          state_nxt_s = S_RUN;
        end else if (branch_ok_s) begin
          flush_nxt_s = 1'b1;
          if (target_s[1]) begin
            // PC stays put; the trap unit decides where to go next.
            misaligned_nxt_s = 1'b1;
            state_nxt_s      = S_WAIT_TRAP;
          end else begin
            pc_nxt_s    = target_s;
            count_nxt_s = count_inc_s;
            state_nxt_s = S_FLUSH;
          end
        end else begin
          pc_nxt_s = pc_r + 32'd4;
        end
      end
      S_FLUSH: begin
        // The branch input belongs to the killed instruction here.
        if (trap_taken_in) begin
          pc_nxt_s    = trap_address_in;
          flush_nxt_s = 1'b1;
          state_nxt_s = S_FLUSH;
        end else if (stall_in) begin
          state_nxt_s = S_RUN;
        end else begin
          pc_nxt_s    = pc_r + 32'd4;
          state_nxt_s = S_RUN;
        end
      end
      S_WAIT_TRAP: begin
        if (trap_taken_in) begin
          pc_nxt_s    = trap_address_in;
          flush_nxt_s = 1'b1;
          state_nxt_s = S_FLUSH;
        end else begin
          state_nxt_s = S_WAIT_TRAP;
        end
      end
      default: begin
        state_nxt_s = S_RUN;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_r      <= S_BOOT;
      pc_r         <= BOOT_ADDRESS;
      flush_r      <= 1'b0;
      misaligned_r <= 1'b0;
      count_r      <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      flush_r      <= flush_nxt_s;
      misaligned_r <= misaligned_nxt_s;
      count_r      <= count_nxt_s;
    end
  end

  assign pc_out               = pc_r;
  assign pc_plus_4_out        = pc_r + 32'd4;
  assign flush_out            = flush_r;
  assign misaligned_instr_out = misaligned_r;
  assign taken_count_out      = count_r;

endmodule

// File: tb/tb_msrv32_pc_redirect_unit.sv
module tb_msrv32_pc_redirect_unit;

  localparam logic [31:0] BOOT = 32'h0000_1000;
  localparam logic [31:0] SAT_MAX = 32'd15;
  localparam logic [4:0] JAL = 5'b11011, JALR = 5'b11001, BR = 5'b11000;

  logic clk = 1'b0;
  logic rst, br_taken, stall, trap;
  logic [4:0] opc;
  logic [31:0] pc_ex, rs1, imm, taddr;
  logic [31:0] pc_o, pc4_o, cnt_o, pc_s, pc4_s, cnt_s;
  logic flush_o, mis_o, flush_s, mis_s;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  msrv32_pc_redirect_unit #(.BOOT_ADDRESS(BOOT)) dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .branch_taken_in(br_taken), .opcode_6_to_2_in(opc), .pc_ex_in(pc_ex),
    .rs1_in(rs1), .imm_in(imm), .stall_in(stall), .trap_taken_in(trap),
    .trap_address_in(taddr), .pc_out(pc_o), .pc_plus_4_out(pc4_o),
    .flush_out(flush_o), .misaligned_instr_out(mis_o), .taken_count_out(cnt_o));

  // Second instance with a low saturation point so the ceiling is reachable.
  msrv32_pc_redirect_unit #(.BOOT_ADDRESS(BOOT), .TAKEN_COUNT_MAX(SAT_MAX)) dut_sat (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .branch_taken_in(br_taken), .opcode_6_to_2_in(opc), .pc_ex_in(pc_ex),
    .rs1_in(rs1), .imm_in(imm), .stall_in(stall), .trap_taken_in(trap),
    .trap_address_in(taddr), .pc_out(pc_s), .pc_plus_4_out(pc4_s),
    .flush_out(flush_s), .misaligned_instr_out(mis_s), .taken_count_out(cnt_s));

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        mis;
    logic [31:0] cnt;
    logic [31:0] cnt_sat;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: mode 0 boot, 1 running, 2 flushing, 3 waiting for trap.
  int          m_mode;
  logic [31:0] m_pc, m_cnt, m_cnt_sat;
  logic        m_flush, m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit is_cti;
    is_cti = br_taken && (opc == JAL || opc == JALR || opc == BR);
    tgt = (opc == JALR) ? ((rs1 + imm) & ~32'd1) : (pc_ex + imm);
    m_flush = 1'b0;
    m_mis = 1'b0;
    if (rst) begin
      m_mode = 0; m_pc = BOOT; m_cnt = 32'd0; m_cnt_sat = 32'd0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (trap) begin
      m_pc = taddr; m_flush = 1'b1; m_mode = 2;
    end else if (m_mode == 1) begin
      if (stall) begin
        m_mode = 1;
      end else if (is_cti && tgt[1]) begin
        m_mis = 1'b1; m_flush = 1'b1; m_mode = 3;
      end else if (is_cti) begin
        m_pc = tgt; m_flush = 1'b1; m_mode = 2;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (m_cnt_sat < SAT_MAX) m_cnt_sat = m_cnt_sat + 32'd1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end else if (m_mode == 2) begin
      if (!stall) m_pc = m_pc + 32'd4;
      m_mode = 1;
    end else begin
      m_mode = 3;
    end
  endtask

  // One clock: evaluate the model on the applied inputs, then queue the
  // expected post-edge outputs.
  task automatic cycle();
    exp_t e;
    model_step();
    e.pc = m_pc; e.flush = m_flush; e.mis = m_mis; e.cnt = m_cnt; e.cnt_sat = m_cnt_sat;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic drive(input logic b, input logic [4:0] op, input logic [31:0] pe,
                       input logic [31:0] r1, input logic [31:0] im, input logic st,
                       input logic tr, input logic [31:0] ta);
    br_taken = b; opc = op; pc_ex = pe; rs1 = r1; imm = im;
    stall = st; trap = tr; taddr = ta; rst = 1'b0;
    cycle();
  endtask

  task automatic idle();
    drive(1'b0, 5'b00100, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // Monitor: compare each queued expectation on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc", pc_o, e.pc);
      chk("pc_plus_4", pc4_o, e.pc + 32'd4);
      chk("flush", {31'd0, flush_o}, {31'd0, e.flush});
      chk("misaligned", {31'd0, mis_o}, {31'd0, e.mis});
      chk("count", cnt_o, e.cnt);
      chk("count_sat", cnt_s, e.cnt_sat);
      chk("pc_sat_inst", pc_s, e.pc);
    end
  end

  initial begin
    rst = 1'b1; br_taken = 1'b0; opc = 5'd0; pc_ex = 32'd0; rs1 = 32'd0;
    imm = 32'd0; stall = 1'b0; trap = 1'b0; taddr = 32'd0;
    m_mode = 0; m_pc = BOOT; m_cnt = 32'd0; m_cnt_sat = 32'd0; m_flush = 1'b0; m_mis = 1'b0;
    @(posedge clk); #1;

    // Reset and free run.
    rst = 1'b1; cycle();
    chk("reset_pc", pc_o, BOOT);
    idle(); idle(); idle();
    chk("freerun_pc", pc_o, 32'h0000_1008);

    // Taken branch, then a wrong-path branch that must be ignored.
    drive(1'b1, BR, 32'h100, 32'd0, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'd0);
    chk("branch_target", pc_o, 32'h0000_00F0);
    chk("branch_flush", {31'd0, flush_o}, 32'd1);
    drive(1'b1, BR, 32'h100, 32'd0, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'd0);
    chk("flush_ignores_branch", pc_o, 32'h0000_00F4);

    // JALR clears bit 0; misaligned JALR waits for the trap.
    drive(1'b1, JALR, 32'h0, 32'h2001, 32'd4, 1'b0, 1'b0, 32'd0);
    chk("jalr_target", pc_o, 32'h0000_2004);
    idle();
    drive(1'b1, JALR, 32'h0, 32'h2002, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("jalr_misaligned", {31'd0, mis_o}, 32'd1);
    drive(1'b1, JAL, 32'h0, 32'h0, 32'h40, 1'b0, 1'b0, 32'd0);
    chk("wait_trap_hold", pc_o, 32'h0000_2008);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80);
    chk("trap_target", pc_o, 32'h0000_0080);
    idle();

    // Stall drops the branch; a trap still wins over the stall.
    drive(1'b1, JAL, 32'h500, 32'd0, 32'h20, 1'b1, 1'b0, 32'd0);
    drive(1'b1, JAL, 32'h500, 32'd0, 32'h20, 1'b1, 1'b1, 32'h300);
    chk("stall_trap", pc_o, 32'h0000_0300);
    idle();

    // Drive the narrow counter past its ceiling with spaced JALs.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, JAL, 32'h400, 32'd0, 32'h8, 1'b0, 1'b0, 32'd0);
      idle();
    end
    chk("count_saturated", cnt_s, SAT_MAX);

    // Reset in the flush cycle.
    drive(1'b1, JAL, 32'h400, 32'd0, 32'h8, 1'b0, 1'b0, 32'd0);
    rst = 1'b1; cycle();
    chk("reset_in_flush_count", cnt_o, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op;
      case ($urandom_range(0, 3))
        0: op = JAL;
        1: op = JALR;
        2: op = BR;
        default: op = 5'($urandom);
      endcase
      drive(($urandom_range(0, 9) < 4), op, $urandom & 32'hFFFF_FFFC, $urandom,
            {$urandom_range(0, 255), 2'($urandom)} - 32'd512,
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5),
            $urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; cycle();
      end
    end

    idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
